// File: rtl/mux_nway_reg_skid.sv
// N:1 operand mux with a registered output, valid/ready handshake and a 2-entry skid buffer.
// Optional MUX_SEL_ERR_EN: drop out-of-range beats and pulse SEL_ERR instead of passing them.
module mux_nway_reg_skid #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned NUM_IN = 4,
  parameter int unsigned SEL_W  = 2
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic [NUM_IN*WIDTH-1:0] D,
  input  logic [SEL_W-1:0]        S,
  input  logic                    IN_VALID,
  output logic                    IN_READY,
  output logic [WIDTH-1:0]        O,
  output logic [SEL_W-1:0]        O_SEL,
  output logic                    OUT_VALID,
  input  logic                    OUT_READY
`ifdef MUX_SEL_ERR_EN
  ,
  output logic                    SEL_ERR
`endif
);

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  main_q, main_d, skid_q, skid_d;
  logic [SEL_W-1:0]  main_sel_q, main_sel_d, skid_sel_q, skid_sel_d;
  logic              in_ready_q;
  logic [WIDTH-1:0]  sel_data;
  logic              accept, store, transfer, out_valid;

  // Out-of-range selects fall through every compare and yield zero.
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < int'(NUM_IN); k++) begin
      if (S == SEL_W'(k)) sel_data = D[k*WIDTH +: WIDTH];
    end
  end

  assign accept    = IN_VALID & in_ready_q;
  assign out_valid = (state_q != StEmpty);
  assign transfer  = out_valid & OUT_READY;

`ifdef MUX_SEL_ERR_EN
  logic sel_in_range;
  logic sel_err_q;
  assign sel_in_range = (32'(S) < NUM_IN);
  assign store        = accept & sel_in_range;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) sel_err_q <= 1'b0;
    else        sel_err_q <= accept & ~sel_in_range;
  end
  assign SEL_ERR = sel_err_q;
`else
  assign store = accept;
`endif

  always_comb begin
    state_d    = state_q;
    main_d     = main_q;
    main_sel_d = main_sel_q;
    skid_d     = skid_q;
    skid_sel_d = skid_sel_q;
    unique case (state_q)
      StEmpty: begin
        if (store) begin
          state_d    = StOne;
          main_d     = sel_data;
          main_sel_d = S;
        end
      end
      StOne: begin
        if (store && transfer) begin
          main_d     = sel_data;
          main_sel_d = S;
        end else if (store) begin
          state_d    = StTwo;
          skid_d     = sel_data;
          skid_sel_d = S;
        end else if (transfer) begin
          state_d = StEmpty;
        end
      end
      StTwo: begin
        // IN_READY is low here, so only a drain of main is possible.
        if (transfer) begin
          state_d    = StOne;
          main_d     = skid_q;
          main_sel_d = skid_sel_q;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= StEmpty;
      main_q     <= '0;
      main_sel_q <= '0;
      skid_q     <= '0;
      skid_sel_q <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      main_sel_q <= main_sel_d;
      skid_q     <= skid_d;
      skid_sel_q <= skid_sel_d;
      in_ready_q <= (state_d != StTwo);
    end
  end

  assign IN_READY  = in_ready_q;
  assign O         = main_q;
  assign O_SEL     = main_sel_q;
  assign OUT_VALID = out_valid;

endmodule
